// File: rtl/hfrv_uart_pkg.sv
// Shared types and constants for the hf-riscv UART receive path.
// Holds the receiver state encoding and the bit-timing preload helper.
package hfrv_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int DEFAULT_CLK_DIV = 434;
    localparam int BIT_CNT_W       = 16;

    // Counter preload that lands the first sample in the middle of the start bit.
    function automatic logic [BIT_CNT_W-1:0] half_bit_preload(input int clk_div);
        half_bit_preload = BIT_CNT_W'(clk_div / 2 - 1);
    endfunction

endpackage

// File: rtl/hfrv_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always visible on head.
// A pop frees its slot before a same-cycle push is judged, so push+pop when full is accepted.
module hfrv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (pop && (cnt_r != CNT_W'(0))) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push && ((cnt_r != CNT_W'(DEPTH)) || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            cnt_r    <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (cnt_r == CNT_W'(DEPTH));
    assign empty = (cnt_r == CNT_W'(0));
    assign count = cnt_r;

endmodule

// File: rtl/hfrv_uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and byte shifter feeding a FWFT FIFO.
// Overrun and framing errors are sticky until clr_err; a same-cycle set beats the clear.
module hfrv_uart_rx
    import hfrv_uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    output logic                          frame_err,
    input  logic                          clr_err
);

    localparam logic [BIT_CNT_W-1:0] FULL_RELOAD = BIT_CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] HALF_RELOAD = half_bit_preload(CLK_DIV);
    localparam logic [2:0]           LAST_BIT    = 3'(UART_DATA_BITS - 1);

    logic                      sync1_r;
    logic                      rxs_r;
    logic                      rxs_prev_r;
    rx_state_t                 state_r;
    logic [BIT_CNT_W-1:0]      bit_cnt_r;
    logic [2:0]                bit_idx_r;
    logic [UART_DATA_BITS-1:0] shreg_r;
    logic                      stop_sample_s;
    logic                      push_s;
    logic                      frame_set_s;
    logic                      overrun_set_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle level is 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r    <= 1'b1;
            rxs_r      <= 1'b1;
            rxs_prev_r <= 1'b1;
        end else begin
            sync1_r    <= rxd;
            rxs_r      <= sync1_r;
            rxs_prev_r <= rxs_r;
        end
    end

    // Stop-bit outcome and error-flag set conditions.
    always_comb begin
        stop_sample_s = 1'b0;
        push_s        = 1'b0;
        frame_set_s   = 1'b0;
        overrun_set_s = 1'b0;
        if ((state_r == STOP) && (bit_cnt_r == BIT_CNT_W'(0))) begin
            stop_sample_s = 1'b1;
        end else begin
            stop_sample_s = 1'b0;
        end
        push_s        = stop_sample_s & rxs_r;
        frame_set_s   = stop_sample_s & ~rxs_r;
        overrun_set_s = push_s & fifo_full_s & ~rd_en;
    end

    // Receive FSM: bit timing, sampling and shifting, LSB first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            bit_cnt_r <= BIT_CNT_W'(0);
            bit_idx_r <= 3'd0;
            shreg_r   <= UART_DATA_BITS'(0);
        end else begin
            case (state_r)
                IDLE: begin
                    if (rxs_prev_r && !rxs_r) begin
                        state_r   <= START;
                        bit_cnt_r <= HALF_RELOAD;
                    end
                end
                START: begin
                    if (bit_cnt_r != BIT_CNT_W'(0)) begin
                        bit_cnt_r <= bit_cnt_r - BIT_CNT_W'(1);
                    end else if (!rxs_r) begin
                        state_r   <= DATA;
                        bit_cnt_r <= FULL_RELOAD;
                        bit_idx_r <= 3'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DATA: begin
                    if (bit_cnt_r != BIT_CNT_W'(0)) begin
                        bit_cnt_r <= bit_cnt_r - BIT_CNT_W'(1);
                    end else begin
                        shreg_r   <= {rxs_r, shreg_r[UART_DATA_BITS-1:1]};
                        bit_cnt_r <= FULL_RELOAD;
                        if (bit_idx_r == LAST_BIT) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_cnt_r != BIT_CNT_W'(0)) begin
                        bit_cnt_r <= bit_cnt_r - BIT_CNT_W'(1);
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set_s) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (overrun_set_s) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    hfrv_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (shreg_r),
        .pop       (rd_en),
        .head      (rd_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (rx_count)
    );

    assign rx_valid = ~fifo_empty_s;

endmodule

// File: tb/tb_hfrv_uart_rx.sv
// Self-checking bench for hfrv_uart_rx: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of received bytes and sticky flags.
module tb_hfrv_uart_rx;

    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT        = 2 + CLK_DIV / 2 + 9 * CLK_DIV + 1;

    logic          clk;
    logic          reset;
    logic          rxd;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rx_valid;
    logic [CW-1:0] rx_count;
    logic          overrun;
    logic          frame_err;
    logic          clr_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rise_cyc;
    bit rand_mode = 1'b0;
    bit prev_valid = 1'b0;

    typedef struct {
        int         due;
        logic [7:0] data;
        bit         ok;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] exp_q[$];
    bit         exp_ovr = 1'b0;
    bit         exp_fe  = 1'b0;
    bit         exp_rst = 1'b0;

    hfrv_uart_rx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .rx_count  (rx_count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame whose line falls right after edge k resolves at edge k+LAT.
    initial begin
        ev_t ev;
        bit  pop_ok, fe_set, ovr_set;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                exp_q.delete();
                ev_q.delete();
                exp_ovr = 1'b0;
                exp_fe  = 1'b0;
                exp_rst = 1'b1;
            end else begin
                exp_rst = 1'b0;
                fe_set  = 1'b0;
                ovr_set = 1'b0;
                pop_ok  = rd_en && (exp_q.size() > 0);
                if (pop_ok) void'(exp_q.pop_front());
                if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
                    ev = ev_q.pop_front();
                    if (!ev.ok) fe_set = 1'b1;
                    else if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(ev.data);
                    else ovr_set = 1'b1;
                end
                if (clr_err) begin
                    exp_fe  = fe_set;
                    exp_ovr = ovr_set;
                end else begin
                    exp_fe  = exp_fe | fe_set;
                    exp_ovr = exp_ovr | ovr_set;
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                chk("cyc_rx_valid", 32'(rx_valid), 32'(exp_q.size() > 0));
                chk("cyc_rx_count", 32'(rx_count), 32'(exp_q.size()));
                chk("cyc_overrun", 32'(overrun), 32'(exp_ovr));
                chk("cyc_frame_err", 32'(frame_err), 32'(exp_fe));
                if (exp_q.size() > 0) chk("cyc_rd_data", 32'(rd_data), 32'(exp_q[0]));
                if (exp_rst) chk("cyc_rd_data_reset", 32'(rd_data), 32'h0);
                if (rx_valid && !prev_valid) rise_cyc = cyc;
                prev_valid = rx_valid;
            end
        end
    end

    task automatic drive_cycle(input logic v, input logic force_rd);
        @(posedge clk);
        #1;
        rxd     = v;
        rd_en   = force_rd | (rand_mode && ($urandom_range(0, 7) == 0));
        clr_err = rand_mode && ($urandom_range(0, 63) == 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input bit pop_at_stop,
                              output int k);
        logic v;
        int   b;
        k = 0;
        for (int off = 0; off < 10 * CLK_DIV; off++) begin
            b = off / CLK_DIV;
            if (b == 0) v = 1'b0;
            else if (b <= 8) v = data[b-1];
            else v = stop;
            drive_cycle(v, pop_at_stop && (off == LAT - 1));
            if (off == 0) begin
                k = cyc;
                ev_q.push_back('{due: cyc + LAT, data: data, ok: stop});
            end
        end
    endtask

    task automatic pop_one(input logic [7:0] exp, input bit last);
        chk("pop_data", 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        if (last) rd_en = 1'b0;
    endtask

    task automatic clr_pulse();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
    endtask

    initial begin
        int         k;
        logic [7:0] partial;
        logic [7:0] rb;
        logic       rs;
        reset = 1'b1; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_rx_valid", 32'(rx_valid), 32'h0);
        chk("reset_rx_count", 32'(rx_count), 32'h0);
        chk("reset_rd_data", 32'(rd_data), 32'h0);
        chk("reset_flags", 32'({overrun, frame_err}), 32'h0);
        reset = 1'b0;
        idle(20);

        // Single byte latency.
        rise_cyc = -1;
        send_frame(8'hA5, 1'b1, 1'b0, k);
        idle(5);
        chk("a5_latency", 32'(rise_cyc - k), 32'd155);
        chk("a5_data", 32'(rd_data), 32'hA5);
        chk("a5_count", 32'(rx_count), 32'd1);
        chk("a5_flags", 32'({overrun, frame_err}), 32'h0);
        pop_one(8'hA5, 1'b1);

        // Back-to-back frames without idle gap.
        send_frame(8'h00, 1'b1, 1'b0, k);
        send_frame(8'hFF, 1'b1, 1'b0, k);
        idle(5);
        chk("b2b_count", 32'(rx_count), 32'd2);
        pop_one(8'h00, 1'b0);
        pop_one(8'hFF, 1'b1);
        chk("b2b_empty", 32'(rx_valid), 32'h0);

        // Start-bit glitch is rejected, next frame is clean.
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0);
        idle(40);
        chk("glitch_count", 32'(rx_count), 32'd0);
        chk("glitch_flags", 32'({overrun, frame_err}), 32'h0);
        send_frame(8'h3C, 1'b1, 1'b0, k);
        idle(5);
        chk("glitch_next_count", 32'(rx_count), 32'd1);
        pop_one(8'h3C, 1'b1);

        // Framing error.
        send_frame(8'h55, 1'b0, 1'b0, k);
        idle(5);
        chk("ferr_set", 32'(frame_err), 32'h1);
        chk("ferr_count", 32'(rx_count), 32'd0);
        clr_pulse();
        chk("ferr_clear", 32'(frame_err), 32'h0);

        // Overrun, then push+pop while full.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, k);
        idle(3);
        chk("ovr_count", 32'(rx_count), 32'd4);
        chk("ovr_flag", 32'(overrun), 32'h1);
        chk("ovr_head", 32'(rd_data), 32'h01);
        send_frame(8'h06, 1'b1, 1'b1, k);
        idle(3);
        chk("ovr_pushpop_count", 32'(rx_count), 32'd4);
        pop_one(8'h02, 1'b0);
        pop_one(8'h03, 1'b0);
        pop_one(8'h04, 1'b0);
        pop_one(8'h06, 1'b1);
        chk("ovr_drained", 32'(rx_valid), 32'h0);
        clr_pulse();
        chk("ovr_clear", 32'(overrun), 32'h0);

        // Reset mid-frame with a byte buffered.
        send_frame(8'h99, 1'b1, 1'b0, k);
        idle(5);
        partial = 8'h81;
        for (int off = 0; off < 4 * CLK_DIV + CLK_DIV / 2; off++)
            drive_cycle((off < CLK_DIV) ? 1'b0 : partial[off / CLK_DIV - 1], 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rxd   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_valid", 32'(rx_valid), 32'h0);
            chk("rst_hold_data", 32'(rd_data), 32'h0);
        end
        reset = 1'b0;
        idle(20);
        send_frame(8'h7E, 1'b1, 1'b0, k);
        idle(5);
        chk("rst_next_count", 32'(rx_count), 32'd1);
        chk("rst_next_data", 32'(rd_data), 32'h7E);
        pop_one(8'h7E, 1'b1);

        // Randomized traffic with random pops and clears.
        rand_mode = 1'b1;
        for (int f = 0; f < 40; f++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 9) != 0);
            send_frame(rb, rs, 1'b0, k);
            idle(rs ? $urandom_range(0, 20) : $urandom_range(2, 20));
        end
        rand_mode = 1'b0;
        idle(5);
        for (int i = 0; i < FIFO_DEPTH + 2; i++) drive_cycle(1'b1, 1'b1);
        idle(3);
        chk("final_empty", 32'(rx_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
